// File: rtl/a_unpack_pkg.sv
// Shared definitions for the a_unpack receive path: data mask, pairing states
// and the even-bit compaction helpers.
package a_pkg;

  localparam logic [7:0] MASK = 8'h55;

  typedef enum logic {LO = 1'b0, HI = 1'b1} pair_state_t;

  function automatic logic [3:0] compact8to4(input logic [7:0] d);
    return {d[6], d[4], d[2], d[0]};
  endfunction

  function automatic logic has_odd_bits(input logic [7:0] d);
    return |(d & ~MASK);
  endfunction

endpackage

// File: rtl/a_unpack_if.sv
// Stream interface of a_unpack: masked bytes in, reassembled bytes out.
interface a_unpack_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/a_unpack_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module a_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  output logic         push_ok_o,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         empty_s, full_s, pop_ok_s, push_ok_s;

  assign empty_s   = (wr_q == rd_q);
  assign full_s    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok_s  = pop_i && !empty_s;
  assign push_ok_s = push_i && (!full_s || pop_ok_s);

  assign push_ok_o = push_ok_s && !flush_i;
  assign valid_o   = !empty_s;
  assign data_o    = empty_s ? {W{1'b0}} : mem_q[rd_q[AW-1:0]];

  // Pointer next-state; flush overrides any push or pop.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = {(AW+1){1'b0}};
      rd_d = {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_d = wr_q + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_d = wr_q;
      end
      if (pop_ok_s) begin
        rd_d = rd_q + {{AW{1'b0}}, 1'b1};
      end else begin
        rd_d = rd_q;
      end
    end
  end

  // Pointer and storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= {(AW+1){1'b0}};
      rd_q <= {(AW+1){1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (push_ok_s && !flush_i) begin
        mem_q[wr_q[AW-1:0]] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/a_unpack.sv
// Receive-side decoder for block `a`: compacts masked bytes to nibbles, pairs
// them into bytes, buffers them in a FIFO and tracks errors and byte counts.
module a_unpack
  import a_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  a_unpack_if.slave        bus,
  input  logic             flush_i,
  output logic             err_odd_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] byte_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  pair_state_t      state_q, state_d;
  logic [3:0]       lo_q, lo_d, nib_s;
  logic             take_s, odd_s, push_s, push_ok_s;
  logic             err_odd_q, err_odd_d, overflow_q, overflow_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d, err_cnt_q, err_cnt_d;

  // A flush discards a concurrent input entirely, including its error check.
  assign take_s = bus.in_valid && !flush_i;
  assign nib_s  = compact8to4(bus.in_data);
  assign odd_s  = take_s && has_odd_bits(bus.in_data);

  a_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .push_i      (push_s),
    .push_data_i ({nib_s, lo_q}),
    .push_ok_o   (push_ok_s),
    .pop_i       (bus.out_ready),
    .valid_o     (bus.out_valid),
    .data_o      (bus.out_data)
  );

  // Pairing FSM: first nibble is latched, second one completes a byte.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    push_s  = 1'b0;
    if (flush_i) begin
      state_d = LO;
    end else if (take_s) begin
      case (state_q)
        LO: begin
          lo_d    = nib_s;
          state_d = HI;
        end
        HI: begin
          push_s  = 1'b1;
          state_d = LO;
        end
        default: state_d = LO;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Status next-state: byte count wraps, error count saturates.
  always_comb begin
    err_odd_d  = err_odd_q | odd_s;
    overflow_d = overflow_q | (push_s && !push_ok_s);
    if (push_ok_s) begin
      byte_cnt_d = byte_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      byte_cnt_d = byte_cnt_q;
    end
    if (odd_s && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State, nibble and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LO;
      lo_q       <= 4'h0;
      err_odd_q  <= 1'b0;
      overflow_q <= 1'b0;
      byte_cnt_q <= {CNT_W{1'b0}};
      err_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      err_odd_q  <= err_odd_d;
      overflow_q <= overflow_d;
      byte_cnt_q <= byte_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_odd_o  = err_odd_q;
  assign overflow_o = overflow_q;
  assign byte_cnt_o = byte_cnt_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_a_unpack.sv
// Self-checking bench for a_unpack: directed table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_a_unpack;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        err_odd, overflow;
  logic [15:0] byte_cnt, err_cnt;

  a_unpack_if bus ();

  a_unpack #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .flush_i    (flush),
    .err_odd_o  (err_odd),
    .overflow_o (overflow),
    .byte_cnt_o (byte_cnt),
    .err_cnt_o  (err_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // reference model state
  logic [7:0]  q_m[$];
  bit          have_lo_m;
  logic [3:0]  lo_m;
  bit          err_m, ovf_m;
  logic [15:0] bcnt_m, ecnt_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] even_bits(input logic [7:0] d);
    logic [3:0] n;
    for (int i = 0; i < 4; i++) n[i] = d[2*i];
    return n;
  endfunction

  function automatic logic [7:0] spread(input logic [3:0] n);
    logic [7:0] d = 8'h00;
    for (int i = 0; i < 4; i++) d[2*i] = n[i];
    return d;
  endfunction

  task automatic model_step(input logic v, input logic [7:0] d, input logic r,
                            input logic f, input logic rs);
    logic [7:0] b;
    if (rs) begin
      q_m.delete(); have_lo_m = 0; lo_m = 4'h0;
      err_m = 0; ovf_m = 0; bcnt_m = 16'h0; ecnt_m = 16'h0;
    end else if (f) begin
      q_m.delete(); have_lo_m = 0;
    end else begin
      if (r && q_m.size() > 0) void'(q_m.pop_front());
      if (v) begin
        if ((d & 8'hAA) != 8'h00) begin
          err_m = 1;
          if (ecnt_m != 16'hFFFF) ecnt_m = ecnt_m + 16'd1;
        end
        if (!have_lo_m) begin
          lo_m = even_bits(d); have_lo_m = 1;
        end else begin
          b = {even_bits(d), lo_m}; have_lo_m = 0;
          if (q_m.size() < DEPTH) begin
            q_m.push_back(b); bcnt_m = bcnt_m + 16'd1;
          end else begin
            ovf_m = 1;
          end
        end
      end
    end
  endtask

  task automatic compare_model();
    chk("out_valid", 32'(bus.out_valid), 32'(q_m.size() != 0));
    if (q_m.size() != 0) chk("out_data", 32'(bus.out_data), 32'(q_m[0]));
    chk("err_odd", 32'(err_odd), 32'(err_m));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    chk("byte_cnt", 32'(byte_cnt), 32'(bcnt_m));
    chk("err_cnt", 32'(err_cnt), 32'(ecnt_m));
  endtask

  // Called at a negedge: apply inputs, advance the model, clock, then compare.
  task automatic drive(input logic v, input logic [7:0] d, input logic r,
                       input logic f, input logic rs);
    bus.in_valid = v; bus.in_data = d; bus.out_ready = r;
    flush = f; rst = rs;
    model_step(v, d, r, f, rs);
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        exp_v;
    logic [7:0]  exp_d;
    logic [15:0] exp_b;
    logic [15:0] exp_e;
  } vec_t;

  vec_t tbl[12];
  logic [7:0] drain_exp[4];

  initial begin
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
    flush = 1'b0; rst = 1'b1;
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("reset_out_data", 32'(bus.out_data), 32'h0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'h0);

    // directed table: pairing, latency, odd-bit errors, byte count
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 8'h00, 16'd0, 16'd0};
    tbl[1]  = '{1'b1, 8'h44, 1'b1, 8'hA1, 16'd1, 16'd0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 16'd1, 16'd0};
    tbl[3]  = '{1'b1, 8'h55, 1'b0, 8'h00, 16'd1, 16'd0};
    tbl[4]  = '{1'b1, 8'h55, 1'b1, 8'hFF, 16'd2, 16'd0};
    tbl[5]  = '{1'b1, 8'h00, 1'b0, 8'h00, 16'd2, 16'd0};
    tbl[6]  = '{1'b1, 8'h00, 1'b1, 8'h00, 16'd3, 16'd0};
    tbl[7]  = '{1'b1, 8'hAA, 1'b0, 8'h00, 16'd3, 16'd1};
    tbl[8]  = '{1'b1, 8'h05, 1'b1, 8'h30, 16'd4, 16'd1};
    tbl[9]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 16'd4, 16'd2};
    tbl[10] = '{1'b1, 8'hFF, 1'b1, 8'hFF, 16'd5, 16'd3};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 16'd5, 16'd3};
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].d, 1'b1, 1'b0, 1'b0);
      chk("tbl_valid", 32'(bus.out_valid), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v) chk("tbl_data", 32'(bus.out_data), 32'(tbl[i].exp_d));
      chk("tbl_byte_cnt", 32'(byte_cnt), 32'(tbl[i].exp_b));
      chk("tbl_err_cnt", 32'(err_cnt), 32'(tbl[i].exp_e));
    end
    chk("tbl_err_odd", 32'(err_odd), 32'h1);

    // overflow: 5 bytes into a 4-deep FIFO with no consumer
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) drive(1'b1, spread(4'(k)), 1'b0, 1'b0, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'h1);
    chk("ovf_byte_cnt", 32'(byte_cnt), 32'd4);
    drain_exp = '{8'h10, 8'h32, 8'h54, 8'h76};
    for (int j = 0; j < 4; j++) begin
      chk("ovf_drain_data", 32'(bus.out_data), 32'(drain_exp[j]));
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("ovf_drained", 32'(bus.out_valid), 32'h0);

    // full FIFO, push and pop in the same cycle
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) drive(1'b1, spread(4'(k)), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("full_pp_overflow", 32'(overflow), 32'h0);
    chk("full_pp_byte_cnt", 32'(byte_cnt), 32'd5);
    for (int j = 0; j < 4; j++) begin
      chk("full_pp_occupancy", 32'(bus.out_valid), 32'h1);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("full_pp_empty", 32'(bus.out_valid), 32'h0);

    // flush mid-pair with a concurrent odd input; sticky state is kept
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
    chk("flush_valid", 32'(bus.out_valid), 32'h0);
    chk("flush_err_cnt", 32'(err_cnt), 32'd1);
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("flush_pair", 32'(bus.out_data), 32'h11);

    // reset mid-pair
    drive(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("rst_flags", 32'({err_odd, overflow, bus.out_valid}), 32'h0);
    chk("rst_counts", 32'({byte_cnt, err_cnt}), 32'h0);
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("rst_pair", 32'(bus.out_data), 32'h11);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 3) != 0) d = d & 8'h55;
      drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
            $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
